// File: rtl/nasti_lite_pkg.sv
// nasti_lite_pkg: response codes and read FSM states shared
// by the NASTI-Lite register slave and its helpers.
package nasti_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_CAPT,
    RD_RESP
  } rd_state_t;

  function automatic logic [1:0] resp_of(input logic ok);
    return ok ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/nasti_lite_hold_reg.sv
// nasti_lite_hold_reg: one-entry valid+payload holding register.
// Load wins over clear; reset empties the entry and zeroes payload.
module nasti_lite_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/nasti_lite_reg_slave.sv
// nasti_lite_reg_slave: NASTI-Lite slave that turns lite AW/W/AR
// traffic into single-cycle register-bank strobes.
module nasti_lite_reg_slave
  import nasti_lite_pkg::*;
#(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int NUM_REGS   = 16,
  localparam int STRB_W    = DATA_WIDTH / 8,
  localparam int IDX_W     =
    (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ID_WIDTH-1:0]   lite_aw_id,
  input  logic [ADDR_WIDTH-1:0] lite_aw_addr,
  input  logic [USER_WIDTH-1:0] lite_aw_user,
  input  logic [2:0]            lite_aw_prot,
  input  logic [3:0]            lite_aw_qos,
  input  logic [3:0]            lite_aw_region,
  input  logic                  lite_aw_valid,
  output logic                  lite_aw_ready,

  input  logic [DATA_WIDTH-1:0] lite_w_data,
  input  logic [STRB_W-1:0]     lite_w_strb,
  input  logic [USER_WIDTH-1:0] lite_w_user,
  input  logic                  lite_w_valid,
  output logic                  lite_w_ready,

  output logic [ID_WIDTH-1:0]   lite_b_id,
  output logic [1:0]            lite_b_resp,
  output logic [USER_WIDTH-1:0] lite_b_user,
  output logic                  lite_b_valid,
  input  logic                  lite_b_ready,

  input  logic [ID_WIDTH-1:0]   lite_ar_id,
  input  logic [ADDR_WIDTH-1:0] lite_ar_addr,
  input  logic [USER_WIDTH-1:0] lite_ar_user,
  input  logic [2:0]            lite_ar_prot,
  input  logic [3:0]            lite_ar_qos,
  input  logic [3:0]            lite_ar_region,
  input  logic                  lite_ar_valid,
  output logic                  lite_ar_ready,

  output logic [ID_WIDTH-1:0]   lite_r_id,
  output logic [DATA_WIDTH-1:0] lite_r_data,
  output logic [1:0]            lite_r_resp,
  output logic [USER_WIDTH-1:0] lite_r_user,
  output logic                  lite_r_valid,
  input  logic                  lite_r_ready,

  output logic                  reg_wen,
  output logic [IDX_W-1:0]      reg_widx,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [STRB_W-1:0]     reg_wstrb,
  output logic                  reg_ren,
  output logic [IDX_W-1:0]      reg_ridx,
  input  logic [DATA_WIDTH-1:0] reg_rdata
);

  localparam int OFF  = $clog2(STRB_W);
  localparam int A_W  = ID_WIDTH + ADDR_WIDTH + USER_WIDTH;
  localparam int W_W  = DATA_WIDTH + STRB_W;
  localparam logic [63:0] LIMIT = 64'(NUM_REGS) << OFF;

  function automatic logic in_range(
    input logic [ADDR_WIDTH-1:0] a
  );
    return 64'(a) < LIMIT;
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(
    input logic [ADDR_WIDTH-1:0] a
  );
    return a[OFF+IDX_W-1:OFF];
  endfunction

  logic                  aw_full;
  logic                  w_full;
  logic                  aw_load;
  logic                  w_load;
  logic                  commit;
  logic                  wr_ok;
  logic [A_W-1:0]        aw_q;
  logic [W_W-1:0]        w_q;
  logic [ID_WIDTH-1:0]   aw_id_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [USER_WIDTH-1:0] aw_user_q;

  assign {aw_id_q, aw_addr_q, aw_user_q} = aw_q;

  // Readies depend only on registered state.
  assign lite_aw_ready = !aw_full && !lite_b_valid;
  assign lite_w_ready  = !w_full && !lite_b_valid;
  assign aw_load = lite_aw_valid && lite_aw_ready;
  assign w_load  = lite_w_valid && lite_w_ready;
  assign commit  = aw_full && w_full;
  assign wr_ok   = in_range(aw_addr_q);

  nasti_lite_hold_reg #(.WIDTH(A_W)) u_aw_hold (
    .clk   (clk),
    .rst   (rst),
    .load  (aw_load),
    .clear (commit),
    .din   ({lite_aw_id, lite_aw_addr, lite_aw_user}),
    .full  (aw_full),
    .dout  (aw_q)
  );

  nasti_lite_hold_reg #(.WIDTH(W_W)) u_w_hold (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .clear (commit),
    .din   ({lite_w_data, lite_w_strb}),
    .full  (w_full),
    .dout  (w_q)
  );

  assign reg_wen  = commit && wr_ok;
  assign reg_widx = idx_of(aw_addr_q);
  assign {reg_wdata, reg_wstrb} = w_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lite_b_valid <= 1'b0;
      lite_b_resp  <= RESP_OKAY;
      lite_b_id    <= '0;
      lite_b_user  <= '0;
    end else if (commit) begin
      lite_b_valid <= 1'b1;
      lite_b_resp  <= resp_of(wr_ok);
      lite_b_id    <= aw_id_q;
      lite_b_user  <= aw_user_q;
    end else if (lite_b_valid && lite_b_ready) begin
      lite_b_valid <= 1'b0;
    end
  end

  rd_state_t             rd_state;
  logic                  ar_full;
  logic                  ar_load;
  logic                  ar_ok;
  logic [A_W-1:0]        ar_q;
  logic [ID_WIDTH-1:0]   ar_id_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [USER_WIDTH-1:0] ar_user_q;

  assign {ar_id_q, ar_addr_q, ar_user_q} = ar_q;
  assign lite_ar_ready = (rd_state == RD_IDLE);
  assign ar_load = lite_ar_valid && lite_ar_ready;
  assign ar_ok   = in_range(ar_addr_q);

  nasti_lite_hold_reg #(.WIDTH(A_W)) u_ar_hold (
    .clk   (clk),
    .rst   (rst),
    .load  (ar_load),
    .clear (lite_r_valid && lite_r_ready),
    .din   ({lite_ar_id, lite_ar_addr, lite_ar_user}),
    .full  (ar_full),
    .dout  (ar_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state     <= RD_IDLE;
      reg_ren      <= 1'b0;
      reg_ridx     <= '0;
      lite_r_valid <= 1'b0;
      lite_r_data  <= '0;
      lite_r_resp  <= RESP_OKAY;
      lite_r_id    <= '0;
      lite_r_user  <= '0;
    end else begin
      unique case (rd_state)
        RD_IDLE: begin
          if (ar_load) begin
            reg_ren  <= in_range(lite_ar_addr);
            reg_ridx <= idx_of(lite_ar_addr);
            rd_state <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          reg_ren  <= 1'b0;
          rd_state <= RD_CAPT;
        end
        // Bank data is valid the cycle after reg_ren.
        RD_CAPT: begin
          lite_r_valid <= 1'b1;
          lite_r_data  <= ar_ok ? reg_rdata : '0;
          lite_r_resp  <= resp_of(ar_ok);
          lite_r_id    <= ar_id_q;
          lite_r_user  <= ar_user_q;
          rd_state     <= RD_RESP;
        end
        RD_RESP: begin
          if (lite_r_ready) begin
            lite_r_valid <= 1'b0;
            rd_state     <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{lite_aw_prot, lite_aw_qos,
                       lite_aw_region, lite_ar_prot,
                       lite_ar_qos, lite_ar_region,
                       lite_w_user, ar_full};

endmodule

// File: tb/tb_nasti_lite_reg_slave.sv
// tb_nasti_lite_reg_slave: random and directed lite traffic checked
// against a byte-strobed register array model.
module tb_nasti_lite_reg_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  lite_aw_id, lite_aw_user;
  logic [7:0]  lite_aw_addr;
  logic [2:0]  lite_aw_prot;
  logic [3:0]  lite_aw_qos, lite_aw_region;
  logic        lite_aw_valid, lite_aw_ready;
  logic [31:0] lite_w_data;
  logic [3:0]  lite_w_strb;
  logic [0:0]  lite_w_user;
  logic        lite_w_valid, lite_w_ready;
  logic [0:0]  lite_b_id, lite_b_user;
  logic [1:0]  lite_b_resp;
  logic        lite_b_valid, lite_b_ready;
  logic [0:0]  lite_ar_id, lite_ar_user;
  logic [7:0]  lite_ar_addr;
  logic [2:0]  lite_ar_prot;
  logic [3:0]  lite_ar_qos, lite_ar_region;
  logic        lite_ar_valid, lite_ar_ready;
  logic [0:0]  lite_r_id, lite_r_user;
  logic [31:0] lite_r_data;
  logic [1:0]  lite_r_resp;
  logic        lite_r_valid, lite_r_ready;
  logic        reg_wen, reg_ren;
  logic [3:0]  reg_widx, reg_ridx, reg_wstrb;
  logic [31:0] reg_wdata, reg_rdata;

  always #5 clk = ~clk;

  nasti_lite_reg_slave dut (
    .clk(clk), .rst(rst),
    .lite_aw_id(lite_aw_id), .lite_aw_addr(lite_aw_addr),
    .lite_aw_user(lite_aw_user), .lite_aw_prot(lite_aw_prot),
    .lite_aw_qos(lite_aw_qos), .lite_aw_region(lite_aw_region),
    .lite_aw_valid(lite_aw_valid), .lite_aw_ready(lite_aw_ready),
    .lite_w_data(lite_w_data), .lite_w_strb(lite_w_strb),
    .lite_w_user(lite_w_user), .lite_w_valid(lite_w_valid),
    .lite_w_ready(lite_w_ready),
    .lite_b_id(lite_b_id), .lite_b_resp(lite_b_resp),
    .lite_b_user(lite_b_user), .lite_b_valid(lite_b_valid),
    .lite_b_ready(lite_b_ready),
    .lite_ar_id(lite_ar_id), .lite_ar_addr(lite_ar_addr),
    .lite_ar_user(lite_ar_user), .lite_ar_prot(lite_ar_prot),
    .lite_ar_qos(lite_ar_qos), .lite_ar_region(lite_ar_region),
    .lite_ar_valid(lite_ar_valid), .lite_ar_ready(lite_ar_ready),
    .lite_r_id(lite_r_id), .lite_r_data(lite_r_data),
    .lite_r_resp(lite_r_resp), .lite_r_user(lite_r_user),
    .lite_r_valid(lite_r_valid), .lite_r_ready(lite_r_ready),
    .reg_wen(reg_wen), .reg_widx(reg_widx),
    .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_ren(reg_ren), .reg_ridx(reg_ridx),
    .reg_rdata(reg_rdata)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Peripheral bank driven by the DUT strobes.
  logic [31:0] bank [16];
  int          wen_cnt = 0;
  int          ren_cnt = 0;
  logic        ren_d = 1'b0;

  always @(negedge clk) begin
    if (reg_ren) begin
      reg_rdata = bank[reg_ridx];
      ren_cnt++;
    end else if (!ren_d) begin
      reg_rdata = $urandom;
    end
    ren_d = reg_ren;
    if (reg_wen) begin
      for (int b = 0; b < 4; b++)
        if (reg_wstrb[b])
          bank[reg_widx][8*b +: 8] = reg_wdata[8*b +: 8];
      wen_cnt++;
    end
  end

  // Reference: word array, 16 regs of 4 bytes.
  logic [31:0] mdl [16];

  function automatic bit inr(input logic [7:0] a);
    return int'(a) < 16 * 4;
  endfunction

  task automatic do_write(input logic [7:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s,
                          input logic id, input logic u,
                          input int awd, input int wd,
                          input int bd);
    bit aw_done, w_done, ok;
    int n, wen0;
    aw_done = 0;
    w_done = 0;
    wen0 = wen_cnt;
    ok = inr(a);
    if (ok)
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[a[5:2]][8*b +: 8] = d[8*b +: 8];
    lite_aw_addr = a;
    lite_aw_id = id;
    lite_aw_user = u;
    lite_w_data = d;
    lite_w_strb = s;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      @(negedge clk);
      if (w_done && !aw_done) begin
        chk("w_rdy_held", lite_w_ready, 0);
        chk("no_early_wen", reg_wen, 0);
      end
      if (aw_done && !w_done)
        chk("aw_rdy_held", lite_aw_ready, 0);
      lite_aw_valid = !aw_done && c >= awd;
      lite_w_valid = !w_done && c >= wd;
      if (lite_aw_valid && lite_aw_ready) aw_done = 1;
      if (lite_w_valid && lite_w_ready) w_done = 1;
    end
    @(negedge clk);
    lite_aw_valid = 0;
    lite_w_valid = 0;
    chk("wen", reg_wen, ok);
    if (ok) begin
      chk("widx", reg_widx, a[5:2]);
      chk("wdata", reg_wdata, d);
      chk("wstrb", reg_wstrb, s);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lite_b_valid && n < 20);
    chk("b_lat", n, 1);
    for (int i = 0; i < bd; i++) begin
      chk("b_hold",
          {lite_b_valid, lite_b_resp, lite_b_id, lite_b_user,
           lite_aw_ready, lite_w_ready},
          {1'b1, ok ? 2'b00 : 2'b10, id, u, 2'b00});
      @(negedge clk);
    end
    chk("b_fields",
        {lite_b_valid, lite_b_resp, lite_b_id, lite_b_user},
        {1'b1, ok ? 2'b00 : 2'b10, id, u});
    lite_b_ready = 1;
    @(negedge clk);
    lite_b_ready = 0;
    chk("b_done",
        {lite_b_valid, lite_aw_ready, lite_w_ready}, 3'b011);
    chk("wen_count", wen_cnt - wen0, ok ? 1 : 0);
  endtask

  task automatic do_read(input logic [7:0] a,
                         input logic id, input logic u,
                         input int rd);
    bit ok;
    int n;
    logic [31:0] ed;
    ok = inr(a);
    ed = ok ? mdl[a[5:2]] : 32'h0;
    @(negedge clk);
    lite_ar_addr = a;
    lite_ar_id = id;
    lite_ar_user = u;
    lite_ar_valid = 1;
    chk("ar_ready", lite_ar_ready, 1);
    @(negedge clk);
    lite_ar_valid = 0;
    chk("ren", reg_ren, ok);
    if (ok) chk("ridx", reg_ridx, a[5:2]);
    chk("ar_busy", lite_ar_ready, 0);
    n = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!lite_r_valid && n < 20);
    chk("r_lat", n, 3);
    for (int i = 0; i < rd; i++) begin
      chk("r_hold",
          {lite_r_valid, lite_r_data, lite_r_resp,
           lite_r_id, lite_r_user, lite_ar_ready},
          {1'b1, ed, ok ? 2'b00 : 2'b10, id, u, 1'b0});
      @(negedge clk);
    end
    chk("r_data", lite_r_data, ed);
    chk("r_meta",
        {lite_r_valid, lite_r_resp, lite_r_id, lite_r_user},
        {1'b1, ok ? 2'b00 : 2'b10, id, u});
    lite_r_ready = 1;
    @(negedge clk);
    lite_r_ready = 0;
    chk("r_done", {lite_r_valid, lite_ar_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wen0, ren0;
    for (int i = 0; i < 16; i++) begin
      bank[i] = 32'h0;
      mdl[i] = 32'h0;
    end
    rst = 1;
    {lite_aw_id, lite_aw_user, lite_aw_addr} = '0;
    {lite_aw_prot, lite_aw_qos, lite_aw_region} = '0;
    {lite_ar_id, lite_ar_user, lite_ar_addr} = '0;
    {lite_ar_prot, lite_ar_qos, lite_ar_region} = '0;
    {lite_w_data, lite_w_strb, lite_w_user} = '0;
    lite_aw_valid = 0;
    lite_w_valid = 0;
    lite_ar_valid = 0;
    lite_b_ready = 0;
    lite_r_ready = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_ready",
        {lite_aw_ready, lite_w_ready, lite_ar_ready}, 3'b111);
    chk("rst_valid",
        {lite_b_valid, lite_r_valid, reg_wen, reg_ren}, 4'b0);
    chk("rst_fields",
        {lite_b_id, lite_b_resp, lite_b_user, lite_r_id,
         lite_r_data, lite_r_resp, lite_r_user}, '0);

    do_write(8'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
    do_write(8'h04, 32'hCAFEF00D, 4'hF, 1, 1, 3, 0, 1);
    bank[3] = 32'h12345678;
    mdl[3] = 32'h12345678;
    do_read(8'h0C, 1, 0, 0);
    do_write(8'h40, 32'h55AA55AA, 4'hF, 0, 1, 0, 0, 0);
    do_read(8'h44, 0, 1, 0);
    do_write(8'h08, 32'h11223344, 4'h5, 1, 0, 0, 2, 5);
    do_write(8'h08, 32'hFFFFFFFF, 4'h0, 0, 0, 1, 1, 0);
    do_read(8'h08, 1, 1, 5);

    @(negedge clk);
    lite_aw_addr = 8'h10;
    lite_aw_valid = 1;
    @(negedge clk);
    lite_aw_valid = 0;
    lite_ar_addr = 8'h14;
    lite_ar_valid = 1;
    @(negedge clk);
    lite_ar_valid = 0;
    @(negedge clk);
    wen0 = wen_cnt;
    ren0 = ren_cnt;
    rst = 1;
    lite_w_data = 32'hA5A5A5A5;
    lite_w_strb = 4'hF;
    lite_w_valid = 1;
    @(negedge clk);
    rst = 0;
    lite_w_valid = 0;
    chk("mid_rst_ready",
        {lite_aw_ready, lite_w_ready, lite_ar_ready}, 3'b111);
    chk("mid_rst_valid",
        {lite_b_valid, lite_r_valid, reg_wen, reg_ren}, 4'b0);
    repeat (4) @(negedge clk);
    chk("mid_rst_no_wen", wen_cnt - wen0, 0);
    chk("mid_rst_no_ren", ren_cnt - ren0, 0);
    chk("mid_rst_idle",
        {lite_b_valid, lite_r_valid, lite_w_ready}, 3'b001);

    for (int it = 0; it < 60; it++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 8'h4F));
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom),
                 1'($urandom), 1'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3));
      else
        do_read(a, 1'($urandom), 1'($urandom),
                $urandom_range(0, 3));
    end

    for (int i = 0; i < 16; i++)
      do_read(8'(i * 4), 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
